// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the slice datapath and data memory.
// Latches an access on start, checks size/alignment, runs the dmem
// request/response handshake with a bounded wait, and returns shifted load
// data plus one-hot load-type strobes for the slices to sign/zero extend.
module lsu_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        lb,
  output logic        lh,
  output logic        lw,
  output logic        lbu,
  output logic        lhu,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Abort fires on the edge where the counter would reach TIMEOUT, so the
  // stored count never exceeds TIMEOUT and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;
  logic              dmem_we_q;
  logic [31:0]       dmem_addr_q;
  logic [3:0]        dmem_wmask_q;
  logic [31:0]       dmem_wdata_q;
  logic [31:0]       load_data_q;
  logic [4:0]        stb_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              legal_d;
  logic [3:0]        wmask_d;
  logic [31:0]       wdata_d;
  logic [4:0]        stb_d;
  logic [31:0]       rdata_shift;

  // Legality check and store lane encoding from the raw start-time inputs.
  always_comb begin
    legal_d = 1'b0;
    wmask_d = 4'b0000;
    wdata_d = 32'h0;
    case (funct3)
      3'b000:  legal_d = 1'b1;
      3'b001:  legal_d = ~addr[0];
      3'b010:  legal_d = (addr[1:0] == 2'b00);
      3'b100:  legal_d = ~is_store;
      3'b101:  legal_d = ~is_store & ~addr[0];
      default: legal_d = 1'b0;
    endcase
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wmask_d = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          wmask_d = 4'b0011 << addr[1:0];
          wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          wmask_d = 4'b1111;
          wdata_d = wdata;
        end
      endcase
    end
  end

  // Load-type strobe decode, byte-lane alignment of the response and timeout compare.
  always_comb begin
    case (funct3_q)
      3'b000:  stb_d = 5'b10000;
      3'b001:  stb_d = 5'b01000;
      3'b010:  stb_d = 5'b00100;
      3'b100:  stb_d = 5'b00010;
      3'b101:  stb_d = 5'b00001;
      default: stb_d = 5'b00000;
    endcase
    rdata_shift = dmem_rdata >> {off_q, 3'b000};
    timeout_hit = (cnt_q >= CNT_LAST);
  end

  // Access sequencer with registered handshake, result and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      cnt_q        <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wmask_q <= 4'b0000;
      dmem_wdata_q <= 32'h0;
      load_data_q  <= 32'h0;
      stb_q        <= 5'b00000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            off_q      <= addr[1:0];
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (legal_d) begin
              dmem_we_q    <= is_store;
              dmem_addr_q  <= {addr[31:2], 2'b00};
              dmem_wmask_q <= wmask_d;
              dmem_wdata_q <= wdata_d;
              state_q      <= REQ;
            end else begin
              stb_q   <= 5'b00000;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem_ready) begin
            if (is_store_q) begin
              stb_q   <= 5'b00000;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeout_hit) begin
            stb_q   <= 5'b00000;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem_rvalid) begin
            load_data_q <= rdata_shift;
            stb_q       <= stb_d;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (timeout_hit) begin
            stb_q   <= 5'b00000;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wmask = dmem_wmask_q;
  assign dmem_wdata = dmem_wdata_q;
  assign load_data  = load_data_q;
  assign {lb, lh, lw, lbu, lhu} = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table for lsu_ctrl plus hand-written
// sequences for timeout-free corner cases (start while busy, reset mid-access).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        lb, lh, lw, lbu, lhu;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_fail = 0;

  lsu_ctrl #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .load_data   (load_data),
    .lb          (lb),
    .lh          (lh),
    .lw          (lw),
    .lbu         (lbu),
    .lhu         (lhu),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          rdly;     // REQ cycles without ready before acceptance
    logic        norv;     // never return rvalid
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_wm;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
    logic [4:0]  exp_stb;  // {lb,lh,lw,lbu,lhu}
    int          exp_lat;  // clock edges from the start edge to the done cycle
    int          exp_reqc; // cycles with dmem_req high
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   reqc;
    logic acc_prev;
    logic got_done;
    logic fields_ok;
    logic busy_ok;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    is_store    = v.st;
    funct3      = v.f3;
    addr        = v.addr;
    wdata       = v.wd;
    start       = 1'b1;
    tick();
    start    = 1'b0;
    is_store = ~v.st;
    funct3   = 3'b111;
    addr     = 32'hFFFF_FFFF;
    wdata    = 32'h5555_AAAA;
    cyc = 1; reqc = 0; acc_prev = 1'b0; got_done = 1'b0; fields_ok = 1'b1; busy_ok = 1'b1;
    while (cyc <= 40) begin
      dmem_rvalid = acc_prev && !v.st && !v.norv;
      dmem_rdata  = dmem_rvalid ? v.rdata : 32'hBAD0_BAD0;
      acc_prev    = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (dmem_req) begin
        reqc++;
        if (dmem_addr !== (v.addr & 32'hFFFF_FFFC) || dmem_we !== v.st) fields_ok = 1'b0;
        if (v.st && (dmem_wmask !== v.exp_wm || dmem_wdata !== v.exp_wd)) fields_ok = 1'b0;
        dmem_ready = (reqc > v.rdly);
        acc_prev   = dmem_ready;
      end else begin
        dmem_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 32'(got_done), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
    chk($sformatf("v%0d_strobes", idx), {27'b0, lb, lh, lw, lbu, lhu}, {27'b0, v.exp_stb});
    chk($sformatf("v%0d_req_cycles", idx), 32'(reqc), 32'(v.exp_reqc));
    chk($sformatf("v%0d_req_fields", idx), 32'(fields_ok), 32'd1);
    chk($sformatf("v%0d_busy_during", idx), 32'(busy_ok), 32'd1);
    tick();
    chk($sformatf("v%0d_idle_after", idx), {29'b0, busy, done, err}, 32'd0);
  endtask

  initial begin
    logic ok;
    vecs[0]  = '{1'b0, 3'b010, 32'h1000_0008, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 5'b00100, 3, 1};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_0003, 32'h0, 0, 1'b0, 32'h8012_3456, 1'b0, 4'h0, 32'h0, 32'h0000_0080, 5'b00010, 3, 1};
    vecs[2]  = '{1'b1, 3'b001, 32'h0000_0020, 32'h1234_ABCD, 3, 1'b0, 32'h0, 1'b0, 4'b0011, 32'hABCD_ABCD, 32'h0000_0080, 5'b00000, 5, 4};
    vecs[3]  = '{1'b1, 3'b000, 32'h0000_0023, 32'h1234_ABCD, 0, 1'b0, 32'h0, 1'b0, 4'b1000, 32'hCDCD_CDCD, 32'h0000_0080, 5'b00000, 2, 1};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_0002, 32'h0, 0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0000_0080, 5'b00000, 1, 0};
    vecs[5]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0000_0080, 5'b00000, 1, 0};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0, 1, 1'b0, 32'hCAFE_1234, 1'b0, 4'h0, 32'h0, 32'h0000_CAFE, 5'b01000, 4, 2};
    vecs[7]  = '{1'b0, 3'b000, 32'h0000_0001, 32'h0, 0, 1'b0, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 32'h0011_2233, 5'b10000, 3, 1};
    vecs[8]  = '{1'b1, 3'b100, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0011_2233, 5'b00000, 1, 0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0104, 32'hFEDC_BA98, 0, 1'b0, 32'h0, 1'b0, 4'hF, 32'hFEDC_BA98, 32'h0011_2233, 5'b00000, 2, 1};
    vecs[10] = '{1'b0, 3'b101, 32'h0000_0006, 32'h0, 0, 1'b0, 32'h8765_4321, 1'b0, 4'h0, 32'h0, 32'h0000_8765, 5'b00001, 3, 1};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0080, 32'h0, 2, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0000_8765, 5'b00000, 9, 3};
    vecs[12] = '{1'b1, 3'b001, 32'h0000_0021, 32'h1, 0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0000_8765, 5'b00000, 1, 0};
    vecs[13] = '{1'b1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D, 99, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0000_8765, 5'b00000, 9, 8};

    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick();
    tick();
    chk("reset_ctrl", {26'b0, dmem_req, dmem_we, busy, done, err, lb}, 32'd0);
    chk("reset_addr", dmem_addr, 32'h0);
    chk("reset_wdata", dmem_wdata, 32'h0);
    chk("reset_load_data", load_data, 32'h0);
    chk("reset_strobes", {27'b0, lb, lh, lw, lbu, lhu, 1'b0} >> 1, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // start pulsed while REQ is pending must not be queued
    is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0200; wdata = 32'h0000_0001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("q_req_up", 32'(dmem_req), 32'd1);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300; start = 1'b1;
    tick();
    start = 1'b0;
    chk("q_addr_kept", dmem_addr, 32'h0000_0200);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("q_done", {30'b0, done, err}, 32'd2);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dmem_req || busy || done) ok = 1'b0;
    end
    chk("q_not_queued", 32'(ok), 32'd1);
    chk("q_addr_after", dmem_addr, 32'h0000_0200);

    // asynchronous reset while waiting for a load response
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; start = 1'b1;
    tick();
    start = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("r_in_wait", {30'b0, dmem_req, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_ctrl_now", {28'b0, dmem_req, busy, done, err}, 32'd0);
    chk("r_load_data_now", load_data, 32'h0);
    chk("r_addr_now", dmem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    tick();
    chk("r_late_rvalid_data", load_data, 32'h0);
    chk("r_late_rvalid_ctrl", {26'b0, busy, done, lb, lh, lw, lbu}, 32'd0);

    run_vec(100, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
